enemy_spawn_scheduler: RTL and testbench
========================================

Name: enemy_spawn_scheduler

Overview:
- Multi-channel successor to the single-lane enemy spawn counter.
- NUM_CH independent frame-rate interval counters; each period is PRBS-derived, scaled by difficulty and clamped to a floor.
- Expiries are queued as pending requests and presented one at a time to the enemy pool over a valid/ack handshake, round-robin.
- Sits between the PRBS generator, the game state FSM and the enemy pool allocator.

Parameters:
- NUM_CH, 4, number of spawn channels (lanes).
- CNT_W, `SPAWN_COUNTER_SIZE (8), counter/period width.
- DIFF_W, 3, difficulty input width.
- MIN_INTERVAL, 4, minimum period after scaling, in frames.
- MISS_W, 8, width of the saturating missed-spawn counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  global run enable (gameplay active).
- frame_tick  in  1  one-cycle pulse per frame (pixel 0, line 0).
- global_tick  in  1  period reload request.
- title_mode  in  1  high while the game FSM is in TITLE; forces period reload every cycle.
- prbs_val  in  CNT_W  current PRBS sample.
- difficulty  in  DIFF_W  right-shift applied to the PRBS sample.
- ch_enb  in  NUM_CH  per-channel count enable.
- spawn_ack  in  1  consumer accepts the presented spawn.
- spawn_valid  out  1  spawn request presented.
- spawn_ch  out  $clog2(NUM_CH)  channel of the presented request.
- pending  out  NUM_CH  queued, unserved expiries.
- miss_cnt  out  MISS_W  saturating count of expiries lost to an already-pending channel.

Behaviour:
- Reset values: all counters 0; all periods all-ones; pending 0; spawn_valid 0; spawn_ch 0; round-robin pointer 0; miss_cnt 0.
- rst mid-handshake drops spawn_valid at the next edge, regardless of spawn_ack.
- Period load happens when global_tick or title_mode is high.
  - period[k] <= max(rotl(prbs_val, k) >> difficulty, MIN_INTERVAL).
  - If difficulty >= CNT_W, the scaled value is 0, so period = MIN_INTERVAL.
  - A load does not touch counters.
- Counting happens only on cycles with enb && frame_tick && ch_enb[k].
  - If counter[k] >= period[k]: counter[k] <= 0 and channel k expires.
  - Otherwise counter[k] increments.
  - The >= compare handles a period shrinking below the live count: expiry occurs on the next counted frame.
  - A disabled channel holds its counter; its pending bit is still served.
  - Counter wrap is impossible, because period <= 2^CNT_W-1.
- Expiry handling for channel k:
  - If pending[k] is 0, or is being cleared by an ack this cycle, then pending[k] <= 1.
  - Otherwise pending[k] stays 1 and miss_cnt increments, saturating at all-ones.
  - Expire and ack clear in the same cycle: set wins, no miss counted.
- Arbitration (registered):
  - Fires when spawn_valid == 0 and pending != 0.
  - Next edge: spawn_valid <= 1, and spawn_ch <= first set pending bit searching upward from rr_ptr, wrapping at NUM_CH.
- Handshake:
  - spawn_valid and spawn_ch stay stable until spawn_ack.
  - On spawn_valid && spawn_ack:
    - pending[spawn_ch] clears (unless re-set per the rule above);
    - rr_ptr <= (spawn_ch+1) mod NUM_CH;
    - spawn_valid <= 0.
  - This gives one mandatory idle cycle between grants.
  - spawn_ack while spawn_valid == 0 is ignored.
- Latency: expiry on frame_tick at edge N -> pending set at N -> spawn_valid high after edge N+1, provided the arbiter is idle.

Decomposition:
- define.v additions:
  - `SPAWN_COUNTER_SIZE reused for CNT_W;
  - `SPAWN_MIN_INTERVAL;
  - `SPAWN_NUM_CH;
  - TITLE state encoding shared with the game FSM, which drives title_mode.
- One sub-module, spawn_rr_arbiter: combinational round-robin first-set search over pending from rr_ptr, returning the index and an any-set flag.
- Counters, period registers, pending/miss logic and handshake registers stay in the top.

Test Plan (NUM_CH=4, CNT_W=8, MIN_INTERVAL=4):
1. Reset: assert rst 2 cycles -> spawn_valid=0, pending=0000, miss_cnt=0; no expiry within 255 frame_ticks after release with no reload.
2. Single lane: ch_enb=0001, prbs_val=0x05, difficulty=0, pulse global_tick, then 6 frame_ticks -> pending=0001 after the 6th tick; next cycle spawn_valid=1, spawn_ch=0; ack -> pending=0000.
3. Clamp and scale: prbs_val=0x10, difficulty=3 (scaled value 2) -> period 4, expiry every 5 frames. difficulty=7 with prbs_val=0xFF -> period 4.
4. Round-robin: force pending=1111, hold spawn_ack=1 -> grants ch 0,1,2,3, each 1 cycle valid, 1 idle cycle; then rr_ptr=0.
5. Miss and same-cycle rules:
   - spawn_ack=0, channel 0 expires twice -> miss_cnt=1, pending[0]=1, spawn_ch stable at 0.
   - Expiry coincident with ack of ch 0 -> pending[0] stays 1, miss_cnt unchanged.
6. Title/reset mid-op:
   - title_mode=1 with prbs_val changing each cycle -> periods track the last sample, counters unchanged.
   - rst while spawn_valid=1 and spawn_ack=0 -> spawn_valid=0 next cycle, pending=0000.

Source files
------------

// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared constants and types for the enemy spawn scheduler slice.
// Pure declarations, no logic and no latency.
// No handshakes; holds the widths and encodings shared with the game FSM.
package enemy_spawn_scheduler_pkg;

    // Counter/period width; also the frame counter width of the old single-lane spawner.
    localparam int SPAWN_COUNTER_SIZE = 8;
    // Shortest allowed spawn period after difficulty scaling, in frames.
    localparam int SPAWN_MIN_INTERVAL = 4;
    // Number of independent spawn lanes.
    localparam int SPAWN_NUM_CH       = 4;

    // Game FSM state encoding; the game FSM drives title_mode from GS_TITLE.
    typedef enum logic [1:0] {
        GS_TITLE = 2'd0,
        GS_PLAY  = 2'd1,
        GS_OVER  = 2'd2
    } game_state_t;

    // Spawn presentation handshake states.
    typedef enum logic {
        SP_IDLE  = 1'b0,
        SP_GRANT = 1'b1
    } spawn_state_t;

endpackage

// File: rtl/enemy_spawn_scheduler_rr_arbiter.sv
// Round-robin first-set search over pending lanes, starting at the pointer.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to register the result.
import enemy_spawn_scheduler_pkg::*;

module spawn_rr_arbiter #(
    parameter int NUM_CH = SPAWN_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_pending,
    input  logic [CH_W-1:0]   i_rr_ptr,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_any
);

    logic [CH_W-1:0] w_idx;
    logic            w_found;

    // Walk upward from the pointer, wrapping, and keep the first pending lane.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            int j;
            j = (int'(i_rr_ptr) + i) % NUM_CH;
            if (!w_found && i_pending[j]) begin
                w_found = 1'b1;
                w_idx   = CH_W'(j);
            end
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_found;

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Multi-lane PRBS-timed spawn scheduler feeding the enemy pool over valid/ack.
// Expiry sets pending at that edge; spawn_valid rises one edge later when idle.
// spawn_valid/spawn_ch hold until ack; one idle cycle between grants; late expiries are counted as misses.
import enemy_spawn_scheduler_pkg::*;

module enemy_spawn_scheduler #(
    parameter int NUM_CH       = SPAWN_NUM_CH,
    parameter int CNT_W        = SPAWN_COUNTER_SIZE,
    parameter int DIFF_W       = 3,
    parameter int MIN_INTERVAL = SPAWN_MIN_INTERVAL,
    parameter int MISS_W       = 8,
    parameter int CH_W         = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enb,
    input  logic              i_frame_tick,
    input  logic              i_global_tick,
    input  logic              i_title_mode,
    input  logic [CNT_W-1:0]  i_prbs_val,
    input  logic [DIFF_W-1:0] i_difficulty,
    input  logic [NUM_CH-1:0] i_ch_enb,
    input  logic              i_spawn_ack,
    output logic              o_spawn_valid,
    output logic [CH_W-1:0]   o_spawn_ch,
    output logic [NUM_CH-1:0] o_pending,
    output logic [MISS_W-1:0] o_miss_cnt
);

    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [CNT_W-1:0]  r_period [NUM_CH];
    logic [CNT_W-1:0]  w_period_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] w_pending_nxt;
    logic [NUM_CH-1:0] w_count;
    logic [NUM_CH-1:0] w_expire;
    logic [NUM_CH-1:0] w_ack_clr;
    logic [NUM_CH-1:0] w_miss;
    logic [MISS_W-1:0] r_miss_cnt;
    logic [MISS_W-1:0] w_miss_cnt_nxt;
    logic [MISS_W:0]   w_miss_sum;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_spawn_ch;
    logic [CH_W-1:0]   w_arb_idx;
    logic              w_arb_any;
    logic              w_load;
    logic              w_ack;
    logic              w_arb_fire;
    spawn_state_t      r_state;
    spawn_state_t      w_state_nxt;

    assign w_load     = i_global_tick | i_title_mode;
    assign w_ack      = (r_state == SP_GRANT) & i_spawn_ack;
    assign w_arb_fire = (r_state == SP_IDLE) & w_arb_any;

    // Candidate period per lane: rotate the PRBS sample by the lane index, scale down, clamp to the floor.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            logic [2*CNT_W-1:0] v_dbl;
            logic [CNT_W-1:0]   v_rot;
            logic [CNT_W-1:0]   v_scaled;
            v_dbl = {i_prbs_val, i_prbs_val} << (k % CNT_W);
            v_rot = v_dbl[2*CNT_W-1:CNT_W];
            if (int'(i_difficulty) >= CNT_W) begin
                v_scaled = '0;
            end else begin
                v_scaled = v_rot >> i_difficulty;
            end
            w_period_nxt[k] = (v_scaled < CNT_W'(MIN_INTERVAL)) ? CNT_W'(MIN_INTERVAL) : v_scaled;
        end
    end

    // Per-lane count qualification, expiry, ack clear and pending update (set beats clear).
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_count[k]       = i_enb & i_frame_tick & i_ch_enb[k];
            w_expire[k]      = w_count[k] & (r_cnt[k] >= r_period[k]);
            w_ack_clr[k]     = w_ack & (r_spawn_ch == CH_W'(k));
            w_miss[k]        = w_expire[k] & r_pending[k] & ~w_ack_clr[k];
            w_pending_nxt[k] = w_expire[k] | (r_pending[k] & ~w_ack_clr[k]);
        end
    end

    // Several lanes may miss in the same frame; add them all and saturate.
    always_comb begin
        w_miss_sum = {1'b0, r_miss_cnt};
        for (int k = 0; k < NUM_CH; k++) begin
            w_miss_sum = w_miss_sum + (MISS_W+1)'(w_miss[k]);
        end
        w_miss_cnt_nxt = w_miss_sum[MISS_W] ? {MISS_W{1'b1}} : w_miss_sum[MISS_W-1:0];
    end

    // Frame counters and period registers; a reload never disturbs the live counts.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_rst) begin
                r_cnt[k]    <= '0;
                r_period[k] <= '1;
            end else begin
                if (w_load) begin
                    r_period[k] <= w_period_nxt[k];
                end
                if (w_expire[k]) begin
                    r_cnt[k] <= '0;
                end else if (w_count[k]) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Pending set and missed-spawn accounting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
        end
    end

    spawn_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .i_pending (r_pending),
        .i_rr_ptr  (r_rr_ptr),
        .o_idx     (w_arb_idx),
        .o_any     (w_arb_any)
    );

    // Handshake state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant when idle with work queued; drop back to idle on ack.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SP_IDLE:  if (w_arb_any)   w_state_nxt = SP_GRANT;
            SP_GRANT: if (i_spawn_ack) w_state_nxt = SP_IDLE;
            default:                   w_state_nxt = SP_IDLE;
        endcase
    end

    // Outputs derived from the handshake state and registered lane/miss state.
    always_comb begin
        o_spawn_valid = (r_state == SP_GRANT);
        o_spawn_ch    = r_spawn_ch;
        o_pending     = r_pending;
        o_miss_cnt    = r_miss_cnt;
    end

    // Capture the granted lane at arbitration; advance the pointer past it on ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_spawn_ch <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_arb_fire) begin
                r_spawn_ch <= w_arb_idx;
            end
            if (w_ack) begin
                r_rr_ptr <= (r_spawn_ch == CH_W'(NUM_CH-1)) ? '0 : r_spawn_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Scoreboarded bench for the enemy spawn scheduler.
// Expected grant lanes are queued as acks are driven and checked when consumed.
// Direct checks cover reset, period scaling/clamp, round-robin, misses, title reload and reset.
module tb_enemy_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       frame_tick;
    logic       global_tick;
    logic       title_mode;
    logic [7:0] prbs_val;
    logic [2:0] difficulty;
    logic [3:0] ch_enb;
    logic       spawn_ack;
    logic       spawn_valid;
    logic [1:0] spawn_ch;
    logic [3:0] pending;
    logic [7:0] miss_cnt;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    enemy_spawn_scheduler dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enb         (enb),
        .i_frame_tick  (frame_tick),
        .i_global_tick (global_tick),
        .i_title_mode  (title_mode),
        .i_prbs_val    (prbs_val),
        .i_difficulty  (difficulty),
        .i_ch_enb      (ch_enb),
        .i_spawn_ack   (spawn_ack),
        .o_spawn_valid (spawn_valid),
        .o_spawn_ch    (spawn_ch),
        .o_pending     (pending),
        .o_miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_period(input logic [7:0] p, input logic [2:0] d);
        prbs_val    = p;
        difficulty  = d;
        global_tick = 1'b1;
        tick();
        global_tick = 1'b0;
    endtask

    task automatic ack_one(input int ch);
        exp_q.push_back(ch);
        spawn_ack = 1'b1;
        tick();
        spawn_ack = 1'b0;
    endtask

    // Consumed grants are popped from the scoreboard and their lane compared.
    always @(negedge clk) begin
        if (rst === 1'b0 && spawn_valid === 1'b1 && spawn_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("grant_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("grant_ch", 32'(spawn_ch), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enb = 1'b0; frame_tick = 1'b0; global_tick = 1'b0;
        title_mode = 1'b0; prbs_val = 8'h00; difficulty = 3'd0;
        ch_enb = 4'b0000; spawn_ack = 1'b0;

        // Reset state, then 255 frames with all-ones periods must not expire.
        do_reset();
        chk("rst_valid",   32'(spawn_valid), 32'd0);
        chk("rst_pending", 32'(pending),     32'h0);
        chk("rst_miss",    32'(miss_cnt),    32'd0);
        chk("rst_ch",      32'(spawn_ch),    32'd0);
        enb = 1'b1; ch_enb = 4'b1111;
        frames(255);
        chk("noexp_255_pending", 32'(pending), 32'h0);
        chk("noexp_255_valid",   32'(spawn_valid), 32'd0);
        do_reset();

        // Single lane, period 5: expires on the 6th frame.
        ch_enb = 4'b0001;
        load_period(8'h05, 3'd0);
        frames(5);
        chk("single_pre_pending", 32'(pending), 32'h0);
        frames(1);
        chk("single_pending", 32'(pending),     32'h1);
        chk("single_valid",   32'(spawn_valid), 32'd1);
        chk("single_ch",      32'(spawn_ch),    32'd0);
        ack_one(0);
        chk("single_ack_pending", 32'(pending),     32'h0);
        chk("single_ack_valid",   32'(spawn_valid), 32'd0);

        // Scale 0x10>>3 = 2, clamped to 4: expiry every 5 frames.
        load_period(8'h10, 3'd3);
        frames(4);
        chk("clamp_a_pre", 32'(pending), 32'h0);
        frames(1);
        chk("clamp_a_exp", 32'(pending), 32'h1);
        ack_one(0);
        // 0xFF>>7 = 1, clamped to 4.
        load_period(8'hFF, 3'd7);
        frames(4);
        chk("clamp_b_pre", 32'(pending), 32'h0);
        frames(1);
        chk("clamp_b_exp", 32'(pending), 32'h1);
        chk("clamp_b_valid", 32'(spawn_valid), 32'd1);
        ack_one(0);

        // Round-robin: all lanes expire together, ack held high.
        do_reset();
        enb = 1'b1; ch_enb = 4'b1111;
        load_period(8'hFF, 3'd7);
        for (int c = 0; c < 4; c++) exp_q.push_back(c);
        spawn_ack = 1'b1;
        frames(5);
        for (int i = 0; i < 8; i++) begin
            chk("rr_valid_pattern", 32'(spawn_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        spawn_ack = 1'b0;
        chk("rr_pending_done", 32'(pending), 32'h0);
        chk("rr_queue_empty",  32'(exp_q.size()), 32'd0);

        // Second expiry on a pending lane counts one miss; grant stays on ch 0.
        ch_enb = 4'b0001;
        frames(5);
        chk("miss_first_pending", 32'(pending), 32'h1);
        frames(5);
        chk("miss_cnt_1",    32'(miss_cnt),    32'd1);
        chk("miss_pending",  32'(pending),     32'h1);
        chk("miss_valid",    32'(spawn_valid), 32'd1);
        chk("miss_ch",       32'(spawn_ch),    32'd0);
        // Expiry coincident with ack of ch 0: set wins, no miss.
        frames(4);
        exp_q.push_back(0);
        frame_tick = 1'b1;
        spawn_ack  = 1'b1;
        tick();
        frame_tick = 1'b0;
        spawn_ack  = 1'b0;
        chk("same_cycle_pending", 32'(pending),  32'h1);
        chk("same_cycle_miss",    32'(miss_cnt), 32'd1);
        chk("same_cycle_idle",    32'(spawn_valid), 32'd0);
        tick();
        chk("regrant_valid", 32'(spawn_valid), 32'd1);
        chk("regrant_ch",    32'(spawn_ch),    32'd0);
        ack_one(0);
        chk("regrant_cleared", 32'(pending), 32'h0);

        // Title mode reloads every cycle; last sample wins, counter keeps its count.
        frames(3);
        title_mode = 1'b1;
        difficulty = 3'd0;
        prbs_val = 8'h30; tick();
        prbs_val = 8'h50; tick();
        prbs_val = 8'h80; tick();
        title_mode = 1'b0;
        frames(125);
        chk("title_pre_pending", 32'(pending), 32'h0);
        frames(1);
        chk("title_exp_pending", 32'(pending),     32'h1);
        chk("title_exp_valid",   32'(spawn_valid), 32'd1);

        // Reset mid-handshake drops valid regardless of ack.
        spawn_ack = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_valid",   32'(spawn_valid), 32'd0);
        chk("midrst_pending", 32'(pending),     32'h0);
        chk("midrst_miss",    32'(miss_cnt),    32'd0);
        rst = 1'b0;
        tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
